// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Purpose  : Parses SOF/ADDR/LEN/payload/CHK frames from a UART byte receiver
//            and commits checksum-verified payload to a register-write port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl #(
  parameter logic [7:0] SOF          = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout
);

  localparam int c_IDX_W  = $clog2(MAX_LEN + 1);
  localparam int c_BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_TCNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]          c_MAX_LEN   = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CHK   = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t               r_state, w_state_nx;
  logic [7:0]           r_addr, w_addr_nx;
  logic [7:0]           r_len, w_len_nx;
  logic [7:0]           r_chk, w_chk_nx;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nx, w_idx_inc;
  logic [c_TCNT_W-1:0]  r_tcnt, w_tcnt_nx;
  logic [7:0]           r_buf [MAX_LEN];
  logic                 w_buf_we;

  logic       r_wr_en, w_wr_en_nx;
  logic [7:0] r_wr_addr, w_wr_addr_nx;
  logic [7:0] r_wr_data, w_wr_data_nx;
  logic       r_busy;
  logic       r_frame_ok, w_frame_ok_nx;
  logic       r_err_chk, w_err_chk_nx;
  logic       r_err_len, w_err_len_nx;
  logic       r_err_timeout, w_err_timeout_nx;

  assign w_idx_inc = r_idx + c_IDX_W'(1);

  always_comb begin
    w_state_nx       = r_state;
    w_addr_nx        = r_addr;
    w_len_nx         = r_len;
    w_chk_nx         = r_chk;
    w_idx_nx         = r_idx;
    w_tcnt_nx        = '0;
    w_buf_we         = 1'b0;
    w_wr_en_nx       = 1'b0;
    w_wr_addr_nx     = 8'h00;
    w_wr_data_nx     = 8'h00;
    w_frame_ok_nx    = 1'b0;
    w_err_chk_nx     = 1'b0;
    w_err_len_nx     = 1'b0;
    w_err_timeout_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SOF)) w_state_nx = S_ADDR;
      end
      S_ADDR, S_LEN, S_DATA, S_CHK: begin
        // A byte on the terminal cycle takes priority over the timeout.
        if (rx_valid) begin
          case (r_state)
            S_ADDR: begin
              w_addr_nx  = rx_data;
              w_chk_nx   = rx_data;
              w_state_nx = S_LEN;
            end
            S_LEN: begin
              w_len_nx = rx_data;
              w_chk_nx = r_chk ^ rx_data;
              w_idx_nx = '0;
              if (rx_data > c_MAX_LEN) begin
                w_err_len_nx = 1'b1;
                w_state_nx   = S_IDLE;
              end else if (rx_data == 8'h00) begin
                w_state_nx = S_CHK;
              end else begin
                w_state_nx = S_DATA;
              end
            end
            S_DATA: begin
              w_buf_we = 1'b1;
              w_chk_nx = r_chk ^ rx_data;
              w_idx_nx = w_idx_inc;
              if (8'(w_idx_inc) == r_len) w_state_nx = S_CHK;
            end
            default: begin
              if (rx_data != r_chk) begin
                w_err_chk_nx = 1'b1;
                w_state_nx   = S_IDLE;
              end else if (r_len == 8'h00) begin
                w_frame_ok_nx = 1'b1;
                w_state_nx    = S_IDLE;
              end else begin
                // First write is issued straight from the checksum byte.
                w_wr_en_nx    = 1'b1;
                w_wr_addr_nx  = r_addr;
                w_wr_data_nx  = r_buf[0];
                w_frame_ok_nx = (r_len == 8'h01);
                w_idx_nx      = c_IDX_W'(1);
                w_state_nx    = S_WRITE;
              end
            end
          endcase
        end else if (r_tcnt == c_TCNT_LAST) begin
          w_err_timeout_nx = 1'b1;
          w_state_nx       = S_IDLE;
        end else begin
          w_tcnt_nx = r_tcnt + c_TCNT_W'(1);
        end
      end
      S_WRITE: begin
        if (8'(r_idx) == r_len) begin
          w_state_nx = S_IDLE;
        end else begin
          w_wr_en_nx    = 1'b1;
          w_wr_addr_nx  = r_addr + 8'(r_idx);
          w_wr_data_nx  = r_buf[r_idx[c_BUF_AW-1:0]];
          w_frame_ok_nx = (8'(w_idx_inc) == r_len);
          w_idx_nx      = w_idx_inc;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_addr        <= 8'h00;
      r_len         <= 8'h00;
      r_chk         <= 8'h00;
      r_idx         <= '0;
      r_tcnt        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 8'h00;
      r_wr_data     <= 8'h00;
      r_busy        <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_addr        <= w_addr_nx;
      r_len         <= w_len_nx;
      r_chk         <= w_chk_nx;
      r_idx         <= w_idx_nx;
      r_tcnt        <= w_tcnt_nx;
      r_wr_en       <= w_wr_en_nx;
      r_wr_addr     <= w_wr_addr_nx;
      r_wr_data     <= w_wr_data_nx;
      r_busy        <= (w_state_nx != S_IDLE);
      r_frame_ok    <= w_frame_ok_nx;
      r_err_chk     <= w_err_chk_nx;
      r_err_len     <= w_err_len_nx;
      r_err_timeout <= w_err_timeout_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx[c_BUF_AW-1:0]] <= rx_data;
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign frame_ok    = r_frame_ok;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Purpose  : Self-checking bench: frame vector table, write scoreboard and
//            hand-written timing, timeout and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

  localparam int         c_T     = 64;
  localparam logic [1:0] c_R_NONE = 2'd0;
  localparam logic [1:0] c_R_OK   = 2'd1;
  localparam logic [1:0] c_R_CHK  = 2'd2;
  localparam logic [1:0] c_R_LEN  = 2'd3;
  localparam int         c_NV    = 9;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic       busy, frame_ok, err_chk, err_len, err_timeout;

  uart_frame_ctrl #(.SOF(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(c_T)) u_dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:11][7:0] b;
    logic [3:0]       n;
    logic [1:0]       res;
    logic [7:0]       waddr;
    logic [2:0]       nwr;
    logic [0:3][7:0]  wdat;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       last;
  } wr_t;

  vec_t vecs [c_NV];
  wr_t  sb [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt_ok = 0, cnt_chk = 0, cnt_len = 0, cnt_to = 0, cnt_wr = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge, after the DUT sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input logic last);
    wr_t e;
    e.a = a; e.d = d; e.last = last;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s_ok, s_chk, s_len, s_to, s_wr;
    s_ok = cnt_ok; s_chk = cnt_chk; s_len = cnt_len; s_to = cnt_to; s_wr = cnt_wr;
    for (int k = 0; k < int'(v.nwr); k++)
      push_wr(v.waddr + 8'(k), v.wdat[k], (k == int'(v.nwr) - 1));
    for (int j = 0; j < int'(v.n); j++) begin
      send_byte(v.b[j]);
      idle(2);
    end
    idle(30);
    check_eq({tag, "_frame_ok"}, cnt_ok - s_ok, (v.res == c_R_OK) ? 1 : 0);
    check_eq({tag, "_err_chk"}, cnt_chk - s_chk, (v.res == c_R_CHK) ? 1 : 0);
    check_eq({tag, "_err_len"}, cnt_len - s_len, (v.res == c_R_LEN) ? 1 : 0);
    check_eq({tag, "_err_timeout"}, cnt_to - s_to, 0);
    check_eq({tag, "_writes"}, cnt_wr - s_wr, 32'(v.nwr));
    check_eq({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Scoreboard / event monitor
  always @(negedge clk) begin : mon
    wr_t e;
    if (rstn) begin
      if (wr_en) begin
        cnt_wr++;
        check_eq("sb_has_entry", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("wr_addr", wr_addr, e.a);
          check_eq("wr_data", wr_data, e.d);
          check_eq("ok_on_last_wr", frame_ok, e.last);
        end
      end
      if (frame_ok)    cnt_ok++;
      if (err_chk)     cnt_chk++;
      if (err_len)     cnt_len++;
      if (err_timeout) cnt_to++;
      if (frame_ok | err_chk | err_len | err_timeout)
        check_eq("pulse_onehot", $countones({frame_ok, err_chk, err_len, err_timeout}), 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int   s_ok, s_to, s_wr;
    logic [7:0] c, p;

    vecs[0] = '{b: {8'hA5,8'h10,8'h02,8'h11,8'h22,8'h21,48'h0}, n: 4'd6, res: c_R_OK,
                waddr: 8'h10, nwr: 3'd2, wdat: {8'h11,8'h22,16'h0}};
    vecs[1] = '{b: {8'hA5,8'hFF,8'h02,8'hAA,8'hBB,8'hEC,48'h0}, n: 4'd6, res: c_R_OK,
                waddr: 8'hFF, nwr: 3'd2, wdat: {8'hAA,8'hBB,16'h0}};
    vecs[2] = '{b: {8'h3C,8'hA5,8'h30,8'h00,8'h30,56'h0}, n: 4'd5, res: c_R_OK,
                waddr: 8'h00, nwr: 3'd0, wdat: 32'h0};
    vecs[3] = '{b: {8'hA5,8'h10,8'h02,8'h11,8'h22,8'h20,48'h0}, n: 4'd6, res: c_R_CHK,
                waddr: 8'h00, nwr: 3'd0, wdat: 32'h0};
    vecs[4] = vecs[0];
    vecs[5] = '{b: {8'hA5,8'h10,8'h11,8'h00,8'h11,56'h0}, n: 4'd5, res: c_R_LEN,
                waddr: 8'h00, nwr: 3'd0, wdat: 32'h0};
    vecs[6] = '{b: {8'hA5,8'hA5,8'h01,8'hA5,8'h01,56'h0}, n: 4'd5, res: c_R_OK,
                waddr: 8'hA5, nwr: 3'd1, wdat: {8'hA5,24'h0}};
    vecs[7] = '{b: {8'hA5,8'h20,8'h01,8'h5A,8'h7B,56'h0}, n: 4'd5, res: c_R_OK,
                waddr: 8'h20, nwr: 3'd1, wdat: {8'h5A,24'h0}};
    vecs[8] = '{b: {8'hA5,8'h30,8'h04,8'h01,8'h02,8'h03,8'h04,8'h30,32'h0}, n: 4'd8,
                res: c_R_OK, waddr: 8'h30, nwr: 3'd4, wdat: {8'h01,8'h02,8'h03,8'h04}};

    idle(3);
    check_eq("reset_outputs", {wr_en, wr_addr, wr_data, busy, frame_ok, err_chk, err_len, err_timeout}, 0);
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < c_NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Write timing of a two-byte frame
    push_wr(8'h10, 8'h11, 1'b0);
    push_wr(8'h11, 8'h22, 1'b1);
    send_byte(8'hA5);
    check_eq("busy_after_sof", busy, 1);
    send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h21);
    check_eq("t_wr0_en", wr_en, 1);
    check_eq("t_wr0_ok", frame_ok, 0);
    idle(1);
    check_eq("t_wr1_en", wr_en, 1);
    check_eq("t_wr1_ok", frame_ok, 1);
    idle(1);
    check_eq("t_after_en", wr_en, 0);
    check_eq("t_after_busy", busy, 0);
    idle(5);

    // Zero-length frame: frame_ok one cycle after the checksum byte
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'h30);
    check_eq("z_ok", frame_ok, 1);
    check_eq("z_wr_en", wr_en, 0);
    idle(1);
    check_eq("z_ok_single", frame_ok, 0);
    idle(5);

    // Oversized LEN: err_len one cycle after the LEN byte
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
    check_eq("l_err_len", err_len, 1);
    check_eq("l_busy", busy, 0);
    idle(1);
    check_eq("l_err_len_single", err_len, 0);
    idle(5);

    // Timeout after the ADDR byte
    s_to = cnt_to;
    send_byte(8'hA5); send_byte(8'h10);
    idle(c_T - 1);
    check_eq("to_early", err_timeout, 0);
    check_eq("to_busy_before", busy, 1);
    idle(1);
    check_eq("to_pulse", err_timeout, 1);
    check_eq("to_busy_after", busy, 0);
    idle(1);
    check_eq("to_single", err_timeout, 0);
    idle(3);
    check_eq("to_count", cnt_to - s_to, 1);

    // Byte arriving on the terminal timeout cycle wins
    s_to = cnt_to; s_ok = cnt_ok;
    push_wr(8'h10, 8'h5A, 1'b1);
    send_byte(8'hA5); send_byte(8'h10);
    idle(c_T - 1);
    send_byte(8'h01);
    check_eq("term_no_to", err_timeout, 0);
    check_eq("term_busy", busy, 1);
    send_byte(8'h5A); send_byte(8'h4B);
    idle(10);
    check_eq("term_to_count", cnt_to - s_to, 0);
    check_eq("term_ok", cnt_ok - s_ok, 1);

    // LEN == MAX_LEN is accepted
    s_ok = cnt_ok; s_wr = cnt_wr;
    c = 8'h40 ^ 8'h10;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      p = 8'(i * 3 + 1);
      c = c ^ p;
      push_wr(8'h40 + 8'(i), p, (i == 15));
      send_byte(p);
    end
    send_byte(c);
    idle(30);
    check_eq("max_ok", cnt_ok - s_ok, 1);
    check_eq("max_writes", cnt_wr - s_wr, 16);
    check_eq("max_sb_left", sb.size(), 0);

    // Reset in the middle of a LEN=4 write burst
    s_wr = cnt_wr;
    push_wr(8'h50, 8'h01, 1'b0);
    push_wr(8'h51, 8'h02, 1'b0);
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h50);
    check_eq("rst_wr0_en", wr_en, 1);
    idle(1);
    check_eq("rst_wr1_en", wr_en, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_outputs", {wr_en, wr_addr, wr_data, busy, frame_ok, err_chk, err_len, err_timeout}, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(10);
    check_eq("rst_writes", cnt_wr - s_wr, 2);
    check_eq("rst_sb_left", sb.size(), 0);
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Frame-level receive controller sitting directly behind the UART byte receiver. It consumes the receiver's one-cycle byte-valid pulse and byte, and parses frames of the form SOF, ADDR, LEN, payload, CHK. Payload bytes are buffered and are only committed to a downstream byte-wide register-write port after the checksum has been verified. Malformed, oversized and stalled frames are rejected with one-cycle error pulses.

Parameters:
SOF, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload bytes, range 1..255. Sets the buffer depth.
TIMEOUT_CLKS, 8680, inter-byte timeout in clk cycles (about 20 bit times at 50 MHz / 115200).

Ports:
clk  in  1  system clock.
rstn  in  1  asynchronous active-low reset.
rx_valid  in  1  one-cycle pulse: rx_data holds a newly received byte.
rx_data  in  8  received byte. Sampled only when rx_valid=1.
wr_en  out  1  register-write strobe, one byte per cycle.
wr_addr  out  8  write address.
wr_data  out  8  write data.
busy  out  1  high in every state except IDLE.
frame_ok  out  1  one-cycle pulse: frame accepted.
err_chk  out  1  one-cycle pulse: checksum mismatch.
err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
err_timeout  out  1  one-cycle pulse: inter-byte timeout.

Behaviour:
- Reset: clk and rstn as already decided (clock clk; reset rstn, asynchronous, active-low).
  - State goes to IDLE.
  - All outputs reset to 0.
  - Buffer contents are don't-care.
  - Reset during any state, including WRITE, aborts the frame immediately. No further wr_en.
- All outputs are registered.
- States: IDLE, ADDR, LEN, DATA, CHK, WRITE.
  - IDLE: rx_valid with rx_data==SOF -> ADDR. Any other byte is discarded.
  - ADDR: on rx_valid, latch addr, set chk=rx_data, -> LEN.
  - LEN: on rx_valid, latch len, chk ^= rx_data.
    - len > MAX_LEN -> err_len pulse next cycle, -> IDLE.
    - len == 0 -> CHK.
    - otherwise -> DATA, idx=0.
  - DATA: on rx_valid, buf[idx]=rx_data, chk ^= rx_data, idx++. When idx reaches len -> CHK.
  - CHK: on rx_valid, compare rx_data with chk.
    - Mismatch -> err_chk pulse next cycle, -> IDLE, no writes.
    - Match and len==0 -> frame_ok pulse next cycle, -> IDLE.
    - Match and len>0 -> WRITE, idx=0.
  - WRITE: wr_en=1 for exactly len consecutive cycles, starting the cycle after the CHK byte.
    - Cycle i: wr_addr = (addr + i) mod 256, wr_data = buf[i].
    - frame_ok pulses in the same cycle as the last wr_en.
    - Then -> IDLE.
    - rx_valid during WRITE is ignored. The integrator guarantees MAX_LEN < one UART byte time in clk cycles.
- Checksum: 8-bit XOR of ADDR, LEN and all payload bytes. SOF is excluded.
- Timeout:
  - Counter is active only in ADDR, LEN, DATA and CHK.
  - It clears on entry to those states and on every rx_valid.
  - Reaching TIMEOUT_CLKS-1 without rx_valid -> err_timeout pulse next cycle, -> IDLE.
  - If rx_valid arrives on the terminal cycle, the byte wins and no timeout is raised.
- At most one of frame_ok, err_chk, err_len, err_timeout is high in any cycle.
- Width rules:
  - idx is wide enough for MAX_LEN.
  - Address wraps modulo 256.
  - Timeout counter is at least clog2(TIMEOUT_CLKS) bits.
- An SOF value arriving as ADDR, LEN, payload or CHK is treated as ordinary data (no resync).

Test Plan:
1. Good frame: A5 10 02 11 22 21 -> wr_en 2 cycles, (10,11) then (11,22). frame_ok on the 2nd write. No errors.
2. Address wrap: A5 FF 02 AA BB EC -> writes (FF,AA) then (00,BB). frame_ok=1 once.
3. Zero length plus garbage: 3C A5 30 00 30 -> 3C ignored. No wr_en. frame_ok one cycle after the CHK byte.
4. Bad checksum: A5 10 02 11 22 20 -> err_chk pulse, zero wr_en. A following good frame from scenario 1 is then accepted normally.
5. Length error (MAX_LEN=16): A5 10 11 -> err_len one cycle after the LEN byte. Following bytes 00 11 are ignored until the next A5.
6. Timeout and reset:
   - A5 10, then no rx_valid for TIMEOUT_CLKS cycles -> single err_timeout pulse, busy falls.
   - Separately, assert rstn=0 mid-WRITE of a LEN=4 frame -> wr_en drops immediately, all outputs 0, and the next frame parses normally.
